apb_master_bridge: RTL and testbench

- Upstream stage for the APB register slaves: converts a simple valid/ready command/response interface into APB SETUP/ACCESS transfers.
- One transfer in flight. Holds address/data stable, waits on PREADY with a bounded timeout, and returns read data plus error status.
- Sits between the internal control logic (sequencer/CPU shim) and the APB slave register files.

---
 rtl/apb_master_bridge_if.sv | 39 +++
 rtl/apb_master_bridge.sv | 105 ++++++++++
 tb/tb_apb_master_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus signals of the APB master bridge.
// The "master" modport is the bridge's view and the "slave" modport is the environment's view.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command to APB SETUP/ACCESS bridge with one transfer in flight,
// a bounded PREADY wait, and a held response until the consumer accepts it.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  apb_master_bridge_if.master        bus,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [CW-1:0]         wait_q, wait_d;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    wait_d   = wait_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          pwrite_d = bus.cmd_write;
          wait_d   = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // PREADY takes priority over a timeout expiring on the same edge
        if (bus.PREADY) begin
          rdata_d = pwrite_q ? '0 : bus.PRDATA;
          err_d   = bus.PSLVERR;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else begin
          if (wait_q != {CW{1'b1}}) wait_d = wait_q + CW'(1);
          if (TMO_EN && (wait_q == WAIT_LAST)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = tmo_q;
  assign bus.PSEL        = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.PENABLE     = (state_q == ACCESS);
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PWDATA      = pwdata_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed and randomized transfers against a transaction-level model of the
// bridge: expected response and ACCESS length derived from slave wait count.
module tb_apb_master_bridge;
  localparam int TMO = 16;

  logic PCLK;
  logic PRESETn;
  logic busy;
  int   checks;
  int   failures;

  apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus),
    .busy    (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Runs one command; waits = PREADY-low ACCESS cycles the slave inserts, bp = cycles rsp_ready held low.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prd, input logic slv, input int bp);
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_to;
    int          exp_en;
    int          en_cycles;
    int          t;
    bit          in_access;
    if (waits >= TMO) begin
      exp_to = 1'b1; exp_err = 1'b1; exp_rd = 32'h0; exp_en = TMO;
    end else begin
      exp_to = 1'b0; exp_err = slv; exp_rd = wr ? 32'h0 : prd; exp_en = waits + 1;
    end

    @(negedge PCLK);
    check("cmd_ready_before", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom; bus.cmd_wdata = $urandom;
    check("setup_psel", bus.PSEL, 1'b1);
    check("setup_penable", bus.PENABLE, 1'b0);
    check("setup_paddr", bus.PADDR, addr);
    check("setup_cmd_ready", bus.cmd_ready, 1'b0);

    en_cycles = 0; t = 0; in_access = 1'b1;
    while (in_access) begin
      @(negedge PCLK);
      t++;
      if (!(bus.PSEL && bus.PENABLE)) begin
        in_access = 1'b0;
      end else if (t > 40) begin
        check("access_bound", 32'(t), 32'd40);
        in_access = 1'b0;
      end else begin
        en_cycles++;
        if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== wdata)
          check("access_hold", {bus.PADDR[15:0], bus.PWDATA[15:0]}, {addr[15:0], wdata[15:0]});
        bus.PREADY  = (en_cycles > waits);
        bus.PRDATA  = bus.PREADY ? prd : $urandom;
        bus.PSLVERR = bus.PREADY ? slv : 1'($urandom);
      end
    end
    bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;

    check("penable_cycles", 32'(en_cycles), 32'(exp_en));
    check("resp_psel", bus.PSEL, 1'b0);
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("rsp_err", bus.rsp_err, exp_err);
    check("rsp_timeout", bus.rsp_timeout, exp_to);

    if (bp > 0) begin
      bus.cmd_valid = 1'b1; bus.cmd_write = ~wr; bus.cmd_addr = addr ^ 32'h100;
      for (int i = 0; i < bp; i++) begin
        @(negedge PCLK);
        check("bp_rsp_valid", bus.rsp_valid, 1'b1);
        check("bp_rsp_rdata", bus.rsp_rdata, exp_rd);
        check("bp_cmd_ready", bus.cmd_ready, 1'b0);
        check("bp_psel", bus.PSEL, 1'b0);
      end
      bus.cmd_valid = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(negedge PCLK);
    bus.rsp_ready = 1'b0;
    check("idle_rsp_valid", bus.rsp_valid, 1'b0);
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_paddr_kept", bus.PADDR, addr);
    $display("xfer wr=%0d addr=%08h waits=%0d rdata=%08h err=%0d to=%0d bp=%0d",
             wr, addr, waits, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout, bp);
  endtask

  initial begin
    checks = 0; failures = 0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0; bus.PRDATA = '0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge PCLK);
    check("rst_psel", bus.PSEL, 1'b0);
    check("rst_penable", bus.PENABLE, 1'b0);
    check("rst_paddr", bus.PADDR, 32'h0);
    check("rst_pwdata", bus.PWDATA, 32'h0);
    check("rst_pwrite", bus.PWRITE, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err", {bus.rsp_err, bus.rsp_timeout}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;

    do_xfer(1'b1, 32'h4,  32'hDEADBEEF, 0,  32'hAAAA5555, 1'b0, 0);
    do_xfer(1'b0, 32'h8,  32'h0,        1,  32'h12345678, 1'b0, 0);
    do_xfer(1'b0, 32'h40, 32'h0,        0,  32'h0000FFFF, 1'b1, 0);
    do_xfer(1'b0, 32'h80, 32'h0,        20, 32'h11112222, 1'b0, 0);
    do_xfer(1'b0, 32'h84, 32'h0,        15, 32'h33334444, 1'b0, 0);
    do_xfer(1'b1, 32'h88, 32'h01020304, 16, 32'h0,        1'b0, 0);
    do_xfer(1'b0, 32'hC0, 32'h0,        2,  32'hCAFEF00D, 1'b0, 5);

    // Reset asserted while ACCESS waits on PREADY
    @(negedge PCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h100;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    check("mid_penable", bus.PENABLE, 1'b1);
    PRESETn = 1'b0;
    #1;
    check("mid_rst_psel", bus.PSEL, 1'b0);
    check("mid_rst_penable", bus.PENABLE, 1'b0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
      check("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
    end
    bus.rsp_ready = 1'b0;

    for (int n = 0; n < 24; n++) begin
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] p;
      logic        e;
      int          w;
      int          b;
      wr = 1'($urandom); a = $urandom & 32'hFFFF_FFFC; d = $urandom; p = $urandom;
      e = 1'($urandom); b = int'($urandom_range(0, 3));
      w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
      do_xfer(wr, a, d, w, p, e, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
